// File: rtl/layer_param_sched.sv
// Sequences one layer's bias then weight beats from two valid/ready sources
// onto a single tagged parameter stream, counting beats against latched config.
module layer_param_sched #(
  parameter int DATA_W = 64,
  parameter int BCNT_W = 9,
  parameter int WCNT_W = 16
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic [BCNT_W-1:0] cfg_bias_beats,
  input  logic [WCNT_W-1:0] cfg_weight_beats,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [DATA_W-1:0] bias_data,
  input  logic              bias_valid,
  input  logic              bias_last,
  output logic              bias_ready,
  input  logic [DATA_W-1:0] wt_data,
  input  logic              wt_valid,
  input  logic              wt_last,
  output logic              wt_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  output logic              m_type,
  input  logic              m_ready
);

  typedef enum logic [1:0] {S_IDLE, S_BIAS, S_WEIGHT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WCNT_W-1:0] r_cnt;
  logic [BCNT_W-1:0] r_bias_beats;
  logic [WCNT_W-1:0] r_wt_beats;
  logic              r_err;

  logic              w_start_ok;
  logic              w_beat;
  logic              w_final;
  logic              w_src_last;
  logic [WCNT_W-1:0] w_phase_cnt;

  assign w_start_ok = start && (r_state == S_IDLE);
  assign w_beat     = m_valid && m_ready;
  // Only meaningful in BIAS/WEIGHT, where the selected latched count is nonzero.
  assign w_final    = (r_cnt == (w_phase_cnt - WCNT_W'(1)));
  assign m_last     = m_valid && w_final;
  assign err        = r_err;

  // Zero-latency source mux: the selected source drives the output directly.
  always_comb begin
    m_data      = '0;
    m_valid     = 1'b0;
    m_type      = 1'b0;
    bias_ready  = 1'b0;
    wt_ready    = 1'b0;
    w_src_last  = 1'b0;
    w_phase_cnt = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_BIAS: begin
        m_data      = bias_data;
        m_valid     = bias_valid;
        bias_ready  = m_ready;
        w_src_last  = bias_last;
        w_phase_cnt = WCNT_W'(r_bias_beats);
        busy        = 1'b1;
      end
      S_WEIGHT: begin
        m_data      = wt_data;
        m_valid     = wt_valid;
        m_type      = 1'b1;
        wt_ready    = m_ready;
        w_src_last  = wt_last;
        w_phase_cnt = r_wt_beats;
        busy        = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (cfg_bias_beats != '0)        w_next = S_BIAS;
          else if (cfg_weight_beats != '0) w_next = S_WEIGHT;
          else                             w_next = S_DONE;
        end
      end
      S_BIAS: begin
        if (w_beat && w_final) w_next = (r_wt_beats != '0) ? S_WEIGHT : S_DONE;
      end
      S_WEIGHT: begin
        if (w_beat && w_final) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bias_beats <= '0;
      r_wt_beats   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_bias_beats <= cfg_bias_beats;
        r_wt_beats   <= cfg_weight_beats;
        r_cnt        <= '0;
        r_err        <= 1'b0;
      end
      if (w_beat) begin
        r_cnt <= w_final ? '0 : r_cnt + WCNT_W'(1);
        // Source last is checked only; sequencing follows the latched counts.
        if (w_src_last != w_final) r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer_param_sched.sv
// Randomized bench for layer_param_sched against a beat-index reference model.
module tb_layer_param_sched;
  localparam int DW = 64;
  localparam int BW = 9;
  localparam int WW = 16;

  logic          sclk = 1'b0;
  logic          s_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] cfg_bias_beats = '0;
  logic [WW-1:0] cfg_weight_beats = '0;
  logic          busy, done, err;
  logic [DW-1:0] bias_data = '0;
  logic          bias_valid = 1'b0, bias_last = 1'b0, bias_ready;
  logic [DW-1:0] wt_data = '0;
  logic          wt_valid = 1'b0, wt_last = 1'b0, wt_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, m_type;
  logic          m_ready = 1'b0;

  int   n_total = 0;
  int   n_bad   = 0;
  logic model_err = 1'b0;

  layer_param_sched #(.DATA_W(DW), .BCNT_W(BW), .WCNT_W(WW)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .start(start),
    .cfg_bias_beats(cfg_bias_beats), .cfg_weight_beats(cfg_weight_beats),
    .busy(busy), .done(done), .err(err),
    .bias_data(bias_data), .bias_valid(bias_valid), .bias_last(bias_last), .bias_ready(bias_ready),
    .wt_data(wt_data), .wt_valid(wt_valid), .wt_last(wt_last), .wt_ready(wt_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_type(m_type), .m_ready(m_ready)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".bias_ready"}, 64'(bias_ready), 64'd0);
    check({tag, ".wt_ready"}, 64'(wt_ready), 64'd0);
    check({tag, ".m_valid"}, 64'(m_valid), 64'd0);
    check({tag, ".m_last"}, 64'(m_last), 64'd0);
    check({tag, ".m_type"}, 64'(m_type), 64'd0);
  endtask

  // One layer: nb bias beats then nw weight beats. err_at marks a bias beat whose
  // last flag is inverted; rst_at is a global beat index at which reset is pulled.
  task automatic run_layer(input int nb, input int nw, input int rmode, input int vmode,
                           input int err_at, input int rst_at, input bit ign,
                           input logic [63:0] b0);
    logic [63:0] bq[$];
    logic [63:0] wq[$];
    int total, i, bi, wi, cyc, limit;
    bit inb, bv, wv, exp_v, fin, slast, did_rst;
    total = nb + nw;
    for (int k = 0; k < nb; k++) bq.push_back((k == 0) ? b0 : {$urandom, $urandom});
    for (int k = 0; k < nw; k++) wq.push_back({$urandom, $urandom});
    limit = 40 * total + 20;

    @(posedge sclk); #1;
    start = 1'b1;
    cfg_bias_beats = BW'(nb);
    cfg_weight_beats = WW'(nw);
    bias_valid = 1'b0;
    wt_valid = 1'b0;
    m_ready = 1'($urandom_range(1, 0));
    @(negedge sclk);
    check("start.busy", 64'(busy), 64'd0);
    check("start.done", 64'(done), 64'd0);
    check("start.err", 64'(err), 64'(model_err));
    @(posedge sclk); #1;
    start = 1'b0;
    model_err = 1'b0;

    i = 0; bi = 0; wi = 0; cyc = 0; did_rst = 0;
    while (i < total && cyc < limit && !did_rst) begin
      bv = (bi < nb) && (vmode == 0 || $urandom_range(1, 0) == 1);
      wv = (wi < nw) && (vmode == 0 || $urandom_range(1, 0) == 1);
      bias_valid = bv;
      bias_data  = bv ? bq[bi] : {$urandom, $urandom};
      bias_last  = bv ? ((bi == nb - 1) != (bi == err_at)) : 1'($urandom_range(1, 0));
      wt_valid   = wv;
      wt_data    = wv ? wq[wi] : {$urandom, $urandom};
      wt_last    = wv ? (wi == nw - 1) : 1'($urandom_range(1, 0));
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = ($urandom_range(3, 0) != 0);
      endcase
      if (ign && cyc == 1) begin
        start = 1'b1;
        cfg_bias_beats = BW'($urandom_range(50, 0));
        cfg_weight_beats = WW'($urandom_range(50, 0));
      end else begin
        start = 1'b0;
      end
      if (i == rst_at) s_rst_n = 1'b0;
      @(negedge sclk);
      inb   = (i < nb);
      exp_v = inb ? bv : wv;
      fin   = inb ? (i == nb - 1) : (i == total - 1);
      check("run.busy", 64'(busy), 64'd1);
      check("run.done", 64'(done), 64'd0);
      check("run.err", 64'(err), 64'(model_err));
      check("run.bias_ready", 64'(bias_ready), 64'(inb && m_ready));
      check("run.wt_ready", 64'(wt_ready), 64'(!inb && m_ready));
      check("run.m_valid", 64'(m_valid), 64'(exp_v));
      check("run.m_type", 64'(m_type), 64'(!inb));
      check("run.m_last", 64'(m_last), 64'(exp_v && fin));
      if (exp_v) check("run.m_data", m_data, inb ? bq[bi] : wq[wi]);
      if (exp_v && m_ready) begin
        slast = inb ? bias_last : wt_last;
        if (slast != fin) model_err = 1'b1;
        i++;
        if (inb) bi++; else wi++;
      end
      if (i - (exp_v && m_ready) == rst_at) did_rst = 1;
      @(posedge sclk); #1;
      cyc++;
    end

    start = 1'b0;
    if (did_rst) begin
      s_rst_n = 1'b1;
      model_err = 1'b0;
      bias_valid = 1'b1;
      wt_valid = 1'b1;
      m_ready = 1'b1;
      @(negedge sclk);
      check_idle_outputs("rst");
      check("rst.err", 64'(err), 64'd0);
      @(posedge sclk); #1;
      @(negedge sclk);
      check("rst.nodone", 64'(done), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      return;
    end

    check("timeout", 64'(i), 64'(total));
    // DONE cycle: drive a start that must be ignored, with sources eager.
    start = 1'b1;
    cfg_bias_beats = 1;
    cfg_weight_beats = 1;
    bias_valid = 1'b1;
    wt_valid = 1'b1;
    m_ready = 1'b1;
    @(negedge sclk);
    check("done.done", 64'(done), 64'd1);
    check("done.busy", 64'(busy), 64'd0);
    check("done.bias_ready", 64'(bias_ready), 64'd0);
    check("done.wt_ready", 64'(wt_ready), 64'd0);
    check("done.m_valid", 64'(m_valid), 64'd0);
    check("done.err", 64'(err), 64'(model_err));
    @(posedge sclk); #1;
    start = 1'b0;
    @(negedge sclk);
    check("post.done", 64'(done), 64'd0);
    check("post.busy", 64'(busy), 64'd0);
    @(posedge sclk); #1;
    @(negedge sclk);
    check("post2.busy", 64'(busy), 64'd0);
    check("post2.err", 64'(err), 64'(model_err));
  endtask

  initial begin
    int nb, nw;
    s_rst_n = 1'b0;
    bias_valid = 1'b1;
    wt_valid = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    check_idle_outputs("reset");
    check("reset.err", 64'(err), 64'd0);
    @(posedge sclk); #1;
    s_rst_n = 1'b1;

    run_layer(128, 1024, 0, 0, -1, -1, 0, {$urandom, $urandom});
    run_layer(4, 4, 1, 0, -1, -1, 0, {32'd66, 32'd1369});
    run_layer(0, 8, 0, 1, -1, -1, 0, {$urandom, $urandom});
    run_layer(0, 0, 2, 1, -1, -1, 0, {$urandom, $urandom});
    run_layer(4, 4, 0, 0, 2, -1, 0, {$urandom, $urandom});
    run_layer(3, 2, 2, 1, -1, -1, 0, {$urandom, $urandom});
    run_layer(20, 30, 0, 0, -1, 30, 0, {$urandom, $urandom});
    run_layer(5, 5, 2, 1, -1, -1, 0, {$urandom, $urandom});
    run_layer(10, 10, 2, 1, -1, -1, 1, {$urandom, $urandom});
    run_layer(6, 0, 0, 1, 5, -1, 0, {$urandom, $urandom});
    for (int n = 0; n < 12; n++) begin
      nb = $urandom_range(20, 0);
      nw = $urandom_range(40, 0);
      run_layer(nb, nw, $urandom_range(2, 0), $urandom_range(1, 0),
                ($urandom_range(2, 0) == 0 && nb > 0) ? $urandom_range(nb - 1, 0) : -1,
                -1, 1'($urandom_range(1, 0)), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/layer_param_sched.md
Name: layer_param_sched

Overview:
- Sequences one layer's parameter load into the conv engine's single 64-bit parameter port.
- Takes bias beats first, then weight beats, from two independent valid/ready sources: the bias transmitter and the weight transmitter.
- Each bias beat carries two packed 32-bit signed biases, as the layer bias transmitters produce.
- Counts beats against per-layer config, tags each output beat with its type, reports busy/done, and flags source framing errors.

Parameters:
- DATA_W, 64, width of the data path on both sources and the output.
- BCNT_W, 9, width of the bias beat count (max 511 beats).
- WCNT_W, 16, width of the weight beat count (max 65535 beats).

Ports:
- sclk  in  1  clock
- s_rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- start  in  1  one-cycle start of a layer load; accepted only in IDLE.
- cfg_bias_beats  in  BCNT_W  number of bias beats for the layer; sampled on accepted start.
- cfg_weight_beats  in  WCNT_W  number of weight beats for the layer; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until the cycle before done.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  sticky framing error; cleared by the next accepted start.
- bias_data  in  DATA_W  bias source data.
- bias_valid  in  1  bias source valid.
- bias_last  in  1  bias source last beat.
- bias_ready  out  1  bias source ready.
- wt_data  in  DATA_W  weight source data.
- wt_valid  in  1  weight source valid.
- wt_last  in  1  weight source last beat.
- wt_ready  out  1  weight source ready.
- m_data  out  DATA_W  output data.
- m_valid  out  1  output valid.
- m_last  out  1  final beat of the current phase.
- m_type  out  1  0 = bias beat, 1 = weight beat.
- m_ready  in  1  downstream ready.

Behaviour:
- Reset values (synchronous, on sclk edge with s_rst_n low; all outputs):
  - state = IDLE, both counters = 0, latched config = 0.
  - busy = 0, done = 0, err = 0.
  - bias_ready = 0, wt_ready = 0, m_valid = 0, m_last = 0, m_type = 0.
  - m_data is don't-care while m_valid is low.
- Reset mid-load: abandons the transfer immediately; no done pulse is issued.
- States:
  - IDLE: an accepted start latches the config and clears err.
    - Next state is BIAS if cfg_bias_beats ≠ 0.
    - Else WEIGHT if cfg_weight_beats ≠ 0.
    - Else DONE.
    - start outside IDLE is ignored and has no effect on err.
  - BIAS: the bias source drives the output combinationally, with zero latency.
    - m_data = bias_data, m_valid = bias_valid, bias_ready = m_ready, m_type = 0, wt_ready = 0.
  - WEIGHT: same mux from the weight source.
    - m_data = wt_data, m_valid = wt_valid, wt_ready = m_ready, m_type = 1, bias_ready = 0.
  - DONE: lasts one cycle; done = 1, all readies and m_valid are 0; next state is IDLE.
- Beats and counters:
  - A beat is a cycle with m_valid & m_ready.
  - The phase counter increments per beat.
  - Final beat of a phase is counter == latched count − 1; m_last = 1 on that beat only, qualified with m_valid.
  - On the final beat: the counter clears to 0.
    - BIAS goes to WEIGHT, or to DONE if the weight count is 0.
    - WEIGHT goes to DONE.
- Framing check on each beat:
  - err sets if source last = 1 on a non-final beat.
  - err sets if source last = 0 on the final beat.
  - Sequencing always follows the latched counts, never the source last.
- Holding: when m_ready = 0, the selected source ready is 0; the output mirrors the source, which must hold its data stable.
- busy = 1 in BIAS and WEIGHT; busy = 0 in IDLE and DONE.
- The 0 → 0 config case passes IDLE → DONE and produces only a done pulse one cycle after start.
- Back-to-back operation: a start asserted in the DONE cycle is ignored; start is accepted again from the following IDLE cycle.

Test Plan:
- Normal load: bias = 128, weight = 1024 beats, m_ready = 1, sources always valid with correct last.
  - 128 beats with m_type = 0 and m_last on beat 127, then 1024 beats with m_type = 1 and m_last on beat 1023.
  - done pulses one cycle after the last weight beat; err stays 0.
- Backpressure: m_ready toggles in a 1-on/2-off pattern, bias = 4, weight = 4.
  - The source ready follows m_ready exactly and no beat is lost or duplicated.
  - Output data matches source order, e.g. {66, 1369} packed on bias beat 0.
- Zero counts:
  - bias = 0, weight = 8: the first output beat is a weight beat.
  - bias = 0, weight = 0: done pulses one cycle after start with no ready ever asserted.
- Framing error: bias = 4 with bias_last asserted on beat 2.
  - err = 1 from the next cycle; the block still takes 4 bias beats and then the weight phase; done still pulses.
  - The next start clears err.
- Reset mid-load: pull s_rst_n low during weight beat 10.
  - Next cycle: IDLE, all outputs at reset values, no done pulse.
  - A fresh start then completes normally.
- Start ignored while busy: assert start in BIAS with different config values.
  - Counts and sequencing are unchanged and err is unaffected.
